alu_32b: RTL and testbench

ALU_32B -- requirements
Module: alu_32b

---
 rtl/alu_32b_if.sv | 21 ++
 rtl/alu_32b.sv | 160 ++++++++++++++++
 tb/tb_alu_32b.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_32b_if.sv
// rtl/alu_32b_if.sv - operand/result bundle for the 32-bit ALU
//
// Purpose: groups the ALU operands, the one-hot operation select and the
// registered 64-bit result.
// Signals:
//   x      [31:0]  operand A; the shift/rotate source
//   y      [31:0]  operand B; y[4:0] is the shift/rotate amount
//   ALUopp [15:0]  one-hot operation select; the lowest set bit wins
//   Z      [63:0]  registered result
// Modports:
//   master  drives x/y/ALUopp and observes Z
//   slave   the ALU itself
interface alu_32b_if;
  logic [31:0] x;
  logic [31:0] y;
  logic [15:0] ALUopp;
  logic [63:0] Z;

  modport master (output x, output y, output ALUopp, input Z);
  modport slave  (input x, input y, input ALUopp, output Z);
endinterface

// File: rtl/alu_32b.sv
// rtl/alu_32b.sv - single-cycle 32-bit ALU with a registered 64-bit result
//
// Purpose: computes one operation per cycle from x, y and ALUopp and loads
// the result into Z on the next rising clock edge.
// Ports:
//   clk    system clock; all state updates on the rising edge
//   reset  synchronous, active-high; clears Z and wins over any operation
//   bus    alu_32b_if.slave (x, y, ALUopp in; Z out)
// ALUopp bits: 0 ADD, 1 SUB, 2 NEG, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 ROR,
//              8 ROL, 9 SLL, 10 SRA, 11 SRL, 12 NOT, 13 INC; 14-15 reserved.

// Shared 32-bit adder; the carry-out is deliberately not produced.
module adder_32b (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum
);
  assign o_sum = i_a + i_b + {31'b0, i_cin};
endmodule

// Combinational signed 32x32 -> 64 multiplier.
module multiplier_32b (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_product
);
  logic signed [63:0] w_a_ext;
  logic signed [63:0] w_b_ext;

  assign w_a_ext   = {{32{i_a[31]}}, i_a};
  assign w_b_ext   = {{32{i_b[31]}}, i_b};
  assign o_product = w_a_ext * w_b_ext;
endmodule

module alu_32b (
  input  logic       clk,
  input  logic       reset,
  alu_32b_if.slave   bus
);

  function automatic logic [31:0] bit_reverse(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic [63:0] r_z;
  logic [63:0] w_result;

  // Adder operand steering: ADD x+y, SUB x+~y+1, NEG 0+~x+1, INC x+1.
  // Same priority order as the result mux so the adder serves the winner.
  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic        w_add_cin;
  logic [31:0] w_add_sum;

  always_comb begin
    w_add_a   = bus.x;
    w_add_b   = 32'h0;
    w_add_cin = 1'b1;
    casez (bus.ALUopp)
      16'b????_????_????_???1: begin w_add_a = bus.x; w_add_b = bus.y;  w_add_cin = 1'b0; end
      16'b????_????_????_??10: begin w_add_a = bus.x; w_add_b = ~bus.y; w_add_cin = 1'b1; end
      16'b????_????_????_?100: begin w_add_a = '0;    w_add_b = ~bus.x; w_add_cin = 1'b1; end
      default:                 begin w_add_a = bus.x; w_add_b = 32'h0;  w_add_cin = 1'b1; end
    endcase
  end

  adder_32b u_adder (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (w_add_cin),
    .o_sum (w_add_sum)
  );

  logic [63:0] w_product;

  multiplier_32b u_mul (
    .i_a       (bus.x),
    .i_b       (bus.y),
    .o_product (w_product)
  );

  // Unsigned divide; divide-by-zero yields all-ones quotient and x as remainder.
  logic [63:0] w_div;
  logic        w_y_zero;

  assign w_y_zero = (bus.y == 32'h0);
  assign w_div    = w_y_zero ? {bus.x, 32'hFFFF_FFFF}
                             : {bus.x % bus.y, bus.x / bus.y};

  // One right-shifting barrel serves all five shift/rotate ops. Left ops
  // bit-reverse the operand in and the result out, which turns a right
  // rotate/logical shift into the matching left one.
  logic       w_left;
  logic       w_rot;
  logic       w_arith;

  always_comb begin
    w_left  = 1'b0;
    w_rot   = 1'b0;
    w_arith = 1'b0;
    casez (bus.ALUopp[11:7])
      5'b????1: begin w_rot = 1'b1; end
      5'b???10: begin w_rot = 1'b1; w_left = 1'b1; end
      5'b??100: begin w_left = 1'b1; end
      5'b?1000: begin w_arith = 1'b1; end
      default:  begin end
    endcase
  end

  logic [5:0][31:0] w_bs;
  logic [31:0]      w_shift;

  assign w_bs[0] = w_left ? bit_reverse(bus.x) : bus.x;

  for (genvar k = 0; k < 5; k++) begin : g_barrel
    localparam int S = 16 >> k;
    logic [S-1:0] w_fill;
    always_comb begin
      if (w_rot)        w_fill = w_bs[k][S-1:0];
      else if (w_arith) w_fill = {S{bus.x[31]}};
      else              w_fill = '0;
    end
    assign w_bs[k+1] = bus.y[4-k] ? {w_fill, w_bs[k][31:S]} : w_bs[k];
  end

  assign w_shift = w_left ? bit_reverse(w_bs[5]) : w_bs[5];

  // Lowest-index set bit selects the operation; nothing valid set gives 0.
  always_comb begin
    w_result = 64'h0;
    casez (bus.ALUopp)
      16'b????_????_????_???1,
      16'b????_????_????_??10,
      16'b????_????_????_?100: w_result = {32'h0, w_add_sum};
      16'b????_????_????_1000: w_result = w_product;
      16'b????_????_???1_0000: w_result = w_div;
      16'b????_????_??10_0000: w_result = {32'h0, bus.x & bus.y};
      16'b????_????_?100_0000: w_result = {32'h0, bus.x | bus.y};
      16'b????_????_1000_0000,
      16'b????_???1_0000_0000,
      16'b????_??10_0000_0000,
      16'b????_?100_0000_0000,
      16'b????_1000_0000_0000: w_result = {32'h0, w_shift};
      16'b???1_0000_0000_0000: w_result = {32'h0, ~bus.x};
      16'b??10_0000_0000_0000: w_result = {32'h0, w_add_sum};
      default:                 w_result = 64'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_z <= 64'h0;
    else       r_z <= w_result;
  end

  assign bus.Z = r_z;

endmodule

// File: tb/tb_alu_32b.sv
// tb/tb_alu_32b.sv - self-checking bench for alu_32b
module tb_alu_32b;

  localparam logic [15:0] OP_ADD = 16'h0001;
  localparam logic [15:0] OP_SUB = 16'h0002;
  localparam logic [15:0] OP_NEG = 16'h0004;
  localparam logic [15:0] OP_MUL = 16'h0008;
  localparam logic [15:0] OP_DIV = 16'h0010;
  localparam logic [15:0] OP_AND = 16'h0020;
  localparam logic [15:0] OP_OR  = 16'h0040;
  localparam logic [15:0] OP_ROR = 16'h0080;
  localparam logic [15:0] OP_ROL = 16'h0100;
  localparam logic [15:0] OP_SLL = 16'h0200;
  localparam logic [15:0] OP_SRA = 16'h0400;
  localparam logic [15:0] OP_SRL = 16'h0800;
  localparam logic [15:0] OP_NOT = 16'h1000;
  localparam logic [15:0] OP_INC = 16'h2000;

  typedef struct {
    string       name;
    logic [15:0] op;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] z;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];

  alu_32b_if bus ();

  alu_32b dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input string name, input logic [15:0] op, input logic [31:0] x,
                     input logic [31:0] y, input logic [63:0] z);
    vec_t v;
    v.name = name; v.op = op; v.x = x; v.y = y; v.z = z;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [15:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.ALUopp = op;
    bus.x      = x;
    bus.y      = y;
  endtask

  initial begin
    add("add_10_5",      OP_ADD, 32'd10,        32'd5,         64'd15);
    add("sub_15_5",      OP_SUB, 32'd15,        32'd5,         64'd10);
    add("sub_5_10",      OP_SUB, 32'd5,         32'd10,        64'h0000_0000_FFFF_FFFB);
    add("add_wrap",      OP_ADD, 32'hFFFF_FFFF, 32'd1,         64'h0);
    add("neg_7",         OP_NEG, 32'd7,         32'd0,         64'h0000_0000_FFFF_FFF9);
    add("inc_wrap",      OP_INC, 32'hFFFF_FFFF, 32'd9,         64'h0);
    add("mul_4_3",       OP_MUL, 32'd4,         32'd3,         64'd12);
    add("mul_m2_3",      OP_MUL, 32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA);
    add("mul_m1_m1",     OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    add("mul_min_min",   OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    add("div_20_5",      OP_DIV, 32'd20,        32'd5,         64'h0000_0000_0000_0004);
    add("div_23_5",      OP_DIV, 32'd23,        32'd5,         64'h0000_0003_0000_0004);
    add("div_big_2",     OP_DIV, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_7FFF_FFFF);
    add("div_7_0",       OP_DIV, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF);
    add("and",           OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 64'h0);
    add("or",            OP_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 64'h0000_0000_FFFF_FFFF);
    add("not",           OP_NOT, 32'hAAAA_AAAA, 32'h0,         64'h0000_0000_5555_5555);
    add("ror_1",         OP_ROR, 32'h8000_0001, 32'd1,         64'h0000_0000_C000_0000);
    add("rol_1",         OP_ROL, 32'h4000_0000, 32'd1,         64'h0000_0000_8000_0000);
    add("ror_0",         OP_ROR, 32'h1234_5678, 32'hFFFF_FFE0, 64'h0000_0000_1234_5678);
    add("rol_8",         OP_ROL, 32'h1234_5678, 32'd8,         64'h0000_0000_3456_7812);
    add("ror_31",        OP_ROR, 32'h0000_0001, 32'd31,        64'h0000_0000_0000_0002);
    add("sll_2",         OP_SLL, 32'd1,         32'd2,         64'd4);
    add("sll_y21",       OP_SLL, 32'd1,         32'h0000_0021, 64'd2);
    add("sll_31",        OP_SLL, 32'd3,         32'd31,        64'h0000_0000_8000_0000);
    add("sra_2",         OP_SRA, 32'h8000_0000, 32'd2,         64'h0000_0000_E000_0000);
    add("sra_pos_31",    OP_SRA, 32'h7FFF_FFFF, 32'd31,        64'h0);
    add("srl_2",         OP_SRL, 32'h8000_0000, 32'd2,         64'h0000_0000_2000_0000);
    add("srl_31",        OP_SRL, 32'hFFFF_FFFF, 32'd31,        64'd1);
    add("add_or_sub",    OP_ADD | OP_SUB, 32'd10, 32'd5,       64'd15);
    add("mul_or_and",    OP_MUL | OP_AND, 32'd4,  32'd3,       64'd12);
    add("sra_or_not",    OP_SRA | OP_NOT, 32'h8000_0000, 32'd4, 64'h0000_0000_F800_0000);
    add("op_zero",       16'h0000, 32'd10,      32'd5,         64'h0);
    add("op_reserved",   16'hC000, 32'd10,      32'd5,         64'h0);

    // Reset holds Z at zero even with a multiply presented.
    drive(OP_MUL, 32'd4, 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_state", bus.Z, 64'h0);
    @(posedge clk); #1;
    check("reset_over_mul", bus.Z, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mul_after_reset", bus.Z, 64'd12);

    // Back-to-back vectors, one per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].x, vecs[i].y);
      @(posedge clk); #1;
      check(vecs[i].name, bus.Z, vecs[i].z);
    end

    // Z must hold its previous value until the next edge.
    drive(OP_ADD, 32'd100, 32'd23);
    #3;
    check("latency_hold", bus.Z, 64'h0);
    @(posedge clk); #1;
    check("latency_load", bus.Z, 64'd123);

    // Mid-stream reset wins over an operation, then normal flow resumes.
    reset = 1'b1;
    drive(OP_ADD, 32'd10, 32'd5);
    @(posedge clk); #1;
    check("reset_mid", bus.Z, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("add_after_reset", bus.Z, 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
